// File: rtl/mac_accumulator.sv
// mac_accumulator: accumulates N_PROD unsigned 8-bit products into an ACC_W-bit
// sum and presents the finished dot product through a valid/ready handshake.
// Optional feature: define MAC_ACCUMULATOR_SAT_EN to saturate the accumulator
// at 2^ACC_W-1 on overflow. When it is undefined, the accumulator wraps.
module mac_accumulator #(
   parameter int N_PROD = 4,   // products per dot product, 1..15
   parameter int ACC_W  = 10   // accumulator width, 8..16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       prod_in,
   input  logic             prod_valid,
   output logic             prod_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] sum_out,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [3:0]       count,
   output logic             overflow
);

   typedef enum logic {ACCUM, DONE} state_t;

   localparam logic [3:0] LAST_COUNT = 4'(N_PROD);

   state_t           state, state_next;
   logic [ACC_W-1:0] acc, acc_next;
   logic [3:0]       count_next;
   logic             overflow_next;
   logic [ACC_W:0]   sum_wide;
   logic             carry;
   logic             accept;

   // Handshake, adder and next-state decode for state, acc, count and overflow
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_next    = state;
      acc_next      = acc;
      count_next    = count;
      overflow_next = overflow;

      prod_ready = (state == ACCUM) && !rst && !clear;
      accept     = prod_valid && prod_ready;
      sum_wide   = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod_in};
      carry      = sum_wide[ACC_W];

      if (clear || (state == DONE && sum_ready)) begin
         // Abort, or result taken downstream: start a fresh dot product.
         state_next    = ACCUM;
         acc_next      = '0;
         count_next    = '0;
         overflow_next = 1'b0;
      end else if (accept) begin
`ifdef MAC_ACCUMULATOR_SAT_EN
         // Once clamped, any further non-zero product carries again, so the
         // accumulator stays pinned at full scale for the rest of the product.
         acc_next = carry ? '1 : sum_wide[ACC_W-1:0];
`else
         acc_next = sum_wide[ACC_W-1:0];
`endif
         count_next = count + 4'd1;
         if (carry) begin
            overflow_next = 1'b1;
         end
         if (count_next == LAST_COUNT) begin
            state_next = DONE;
         end
      end
   end

   // State and datapath registers with synchronous reset taking priority
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         state    <= ACCUM;
         acc      <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_next;
         acc      <= acc_next;
         count    <= count_next;
         overflow <= overflow_next;
      end
   end

   assign sum_out   = acc;
   assign sum_valid = (state == DONE);

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed scenarios plus randomized traffic checked
// against an arithmetic model (true running total of accepted products).
// Two instances share all inputs: default widths and ACC_W = 9 for overflow.
module tb_mac_accumulator;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst, prod_valid, clear, sum_ready;
   logic [7:0] prod_in;

   logic       prod_ready, sum_valid, overflow;
   logic [9:0] sum_out;
   logic [3:0] count;
   logic       ready9, valid9, ov9;
   logic [8:0] sum9;
   logic [3:0] count9;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_total = 0;
   int m_count = 0;
   bit m_done  = 1'b0;
   bit exp_ready;
   logic obs_ready, obs_ready9;

   always #5 clk = ~clk;

   mac_accumulator #(.N_PROD(N), .ACC_W(10)) dut (
      .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(prod_ready), .clear(clear), .sum_out(sum_out),
      .sum_valid(sum_valid), .sum_ready(sum_ready), .count(count),
      .overflow(overflow));

   mac_accumulator #(.N_PROD(N), .ACC_W(9)) dut9 (
      .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(ready9), .clear(clear), .sum_out(sum9),
      .sum_valid(valid9), .sum_ready(sum_ready), .count(count9),
      .overflow(ov9));

   // Expected accumulator value for a given true total and width
   function automatic int exp_sum(input int total, input int w);
      int lim;
      lim = (1 << w);
`ifdef MAC_ACCUMULATOR_SAT_EN
      return (total >= lim) ? lim - 1 : total;
`else
      return total % lim;
`endif
   endfunction

   // Apply one cycle of inputs, sample prod_ready before the edge, advance model
   task automatic drive(input logic v, input logic [7:0] p, input logic sr,
                        input logic clr, input logic r);
      prod_valid = v;
      prod_in    = p;
      sum_ready  = sr;
      clear      = clr;
      rst        = r;
      #1;
      obs_ready  = prod_ready;
      obs_ready9 = ready9;
      exp_ready  = !m_done && !r && !clr;
      @(posedge clk);
      if (r || clr || (m_done && sr)) begin
         m_total = 0;
         m_count = 0;
         m_done  = 1'b0;
      end else if (!m_done && v) begin
         m_total += int'(p);
         m_count += 1;
         if (m_count == N) m_done = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 8'd50, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (sum_out !== 10'd0 || sum_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: sum=%0d valid=%b count=%0d ov=%b, required 0 0 0 0",
                  sum_out, sum_valid, count, overflow);
      end
      drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: prod_ready=%b, required 1", obs_ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0] prods [4] = '{8'd15, 8'd30, 8'd45, 8'd60};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, prods[i], 1'b1, 1'b0, 1'b0);
         if (i < 3) begin
            checks++;
            if (sum_valid !== 1'b0 || count !== 4'(i + 1)) begin
               errors++;
               $display("FAIL basic_progress: valid=%b count=%0d, required 0 %0d",
                        sum_valid, count, i + 1);
            end
         end
      end
      checks++;
      if (sum_valid !== 1'b1 || sum_out !== 10'd150 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: valid=%b sum=%0d ov=%b, required 1 150 0",
                  sum_valid, sum_out, overflow);
      end
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (sum_valid !== 1'b0 || sum_out !== 10'd0 || count !== 4'd0) begin
         errors++;
         $display("FAIL basic_release: valid=%b sum=%0d count=%0d, required 0 0 0",
                  sum_valid, sum_out, count);
      end
   endtask

   task automatic test_hold_and_overflow();
      int exp9;
`ifdef MAC_ACCUMULATOR_SAT_EN
      exp9 = 511;
`else
      exp9 = 388;
`endif
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd225, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
         checks++;
         if (sum_out !== 10'd900 || sum_valid !== 1'b1 || obs_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: sum=%0d valid=%b ready=%b, required 900 1 0",
                     sum_out, sum_valid, obs_ready);
         end
         checks++;
         if (int'(sum9) !== exp9 || ov9 !== 1'b1 || valid9 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_w9: sum=%0d ov=%b valid=%b, required %0d 1 1",
                     sum9, ov9, valid9, exp9);
         end
      end
      drive(1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_ready !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 10'd0 || ov9 !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: ready=%b valid=%b sum=%0d ov9=%b, required 0 0 0 0",
                  obs_ready, sum_valid, sum_out, ov9);
      end
   endtask

   task automatic test_clear();
      drive(1'b1, 8'd10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd20, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd99, 1'b1, 1'b1, 1'b0);
      checks++;
      if (obs_ready !== 1'b0 || sum_out !== 10'd0 || count !== 4'd0 || sum_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear_abort: ready=%b sum=%0d count=%0d valid=%b, required 0 0 0 0",
                  obs_ready, sum_out, count, sum_valid);
      end
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (sum_out !== 10'd4 || sum_valid !== 1'b1) begin
         errors++;
         $display("FAIL clear_restart: sum=%0d valid=%b, required 4 1", sum_out, sum_valid);
      end
      drive(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
      checks++;
      if (sum_valid !== 1'b0 || sum_out !== 10'd0) begin
         errors++;
         $display("FAIL clear_in_done: valid=%b sum=%0d, required 0 0", sum_valid, sum_out);
      end
   endtask

   task automatic test_rst_mid();
      for (int i = 0; i < 3; i++) drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'd2, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_ready !== 1'b0 || sum_out !== 10'd0 || count !== 4'd0 || sum_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: ready=%b sum=%0d count=%0d valid=%b, required 0 0 0 0",
                  obs_ready, sum_out, count, sum_valid);
      end
      for (int i = 0; i < 4; i++) drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (sum_valid !== 1'b0 || sum_out !== 10'd0 || count !== 4'd0) begin
         errors++;
         $display("FAIL rst_done: valid=%b sum=%0d count=%0d, required 0 0 0",
                  sum_valid, sum_out, count);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
         if (i == 0) begin
            checks++;
            if (obs_ready !== 1'b1) begin
               errors++;
               $display("FAIL rst_ready: prod_ready=%b, required 1", obs_ready);
            end
         end
      end
      checks++;
      if (sum_out !== 10'd8 || sum_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_restart: sum=%0d valid=%b, required 8 1", sum_out, sum_valid);
      end
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_gaps();
      logic pattern [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int   exp_cnt [7] = '{1, 1, 1, 2, 2, 3, 4};
      for (int i = 0; i < 7; i++) begin
         drive(pattern[i], 8'd5, 1'b0, 1'b0, 1'b0);
         checks++;
         if (int'(count) !== exp_cnt[i] || int'(sum_out) !== 5 * exp_cnt[i]) begin
            errors++;
            $display("FAIL gaps_step%0d: count=%0d sum=%0d, required %0d %0d",
                     i, count, sum_out, exp_cnt[i], 5 * exp_cnt[i]);
         end
      end
      checks++;
      if (sum_valid !== 1'b1 || sum_out !== 10'd20) begin
         errors++;
         $display("FAIL gaps_result: valid=%b sum=%0d, required 1 20", sum_valid, sum_out);
      end
      drive(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, 8'($urandom % 256), ($urandom % 3) != 0,
               ($urandom % 32) == 0, ($urandom % 64) == 0);
         checks++;
         if (obs_ready !== exp_ready || obs_ready9 !== exp_ready) begin
            errors++;
            $display("FAIL rand_ready cyc%0d: ready=%b ready9=%b, required %b",
                     i, obs_ready, obs_ready9, exp_ready);
         end
         checks++;
         if (int'(sum_out) !== exp_sum(m_total, 10) || int'(sum9) !== exp_sum(m_total, 9)) begin
            errors++;
            $display("FAIL rand_sum cyc%0d: sum=%0d sum9=%0d, required %0d %0d",
                     i, sum_out, sum9, exp_sum(m_total, 10), exp_sum(m_total, 9));
         end
         checks++;
         if (sum_valid !== m_done || valid9 !== m_done || int'(count) !== m_count ||
             int'(count9) !== m_count) begin
            errors++;
            $display("FAIL rand_ctrl cyc%0d: valid=%b valid9=%b count=%0d count9=%0d, required %b %0d",
                     i, sum_valid, valid9, count, count9, m_done, m_count);
         end
         checks++;
         if (overflow !== (m_total >= 1024) || ov9 !== (m_total >= 512)) begin
            errors++;
            $display("FAIL rand_ovf cyc%0d: ov=%b ov9=%b, required %b %b",
                     i, overflow, ov9, m_total >= 1024, m_total >= 512);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_and_overflow();
      test_clear();
      test_rst_mid();
      test_gaps();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
